// File: rtl/fact_requester.sv
// Request sequencer for an external factorial unit: issues one go pulse per accepted operand, waits
// for done_in with a timeout, and captures the result. Define FACT_REQ_SELFCHECK_EN to check results against an n! table.
module fact_requester #(
    parameter int TIMEOUT_CYC = 255,
    parameter int N_MAX       = 12
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [3:0]  n_in,
    output logic        go,
    output logic [3:0]  n_out,
    input  logic        done_in,
    input  logic [31:0] result_in,
    output logic [31:0] result,
    output logic        valid,
    output logic        busy,
    output logic        err,
    output logic        mismatch
);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT} state_t;

    localparam logic [3:0] N_MAX_L  = 4'(N_MAX);
    // Last timer value: the TIMEOUT_CYC-th WAIT cycle without done_in ends the request.
    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYC - 1);

    state_t      state_q, state_d;
    logic        go_q, go_d;
    logic [3:0]  n_out_q, n_out_d;
    logic [31:0] result_q, result_d;
    logic        valid_q, valid_d;
    logic        busy_q, busy_d;
    logic        err_q, err_d;
    logic        mismatch_q, mismatch_d;
    logic [7:0]  timer_q, timer_d;

    logic n_ok;
    logic timeout;
    logic capture_bad;

    assign n_ok    = (n_in <= N_MAX_L);
    assign timeout = (timer_q == TMO_LAST);

`ifdef FACT_REQ_SELFCHECK_EN
    function automatic logic [31:0] fact_f(input int n);
        logic [31:0] p;
        p = 32'd1;
        for (int i = 2; i <= n; i++) begin
            p = p * 32'(i);
        end
        return p;
    endfunction

    // Padded to 16 entries so the 4-bit operand indexes it directly.
    logic [31:0] fact_table [16];
    generate
        for (genvar gi = 0; gi < 16; gi++) begin : g_fact
            assign fact_table[gi] = (gi <= N_MAX) ? fact_f(gi) : 32'd0;
        end
    endgenerate

    assign capture_bad = (result_in != fact_table[n_out_q]);
`else
    assign capture_bad = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            go_q       <= 1'b0;
            n_out_q    <= 4'd0;
            result_q   <= 32'd0;
            valid_q    <= 1'b0;
            busy_q     <= 1'b0;
            err_q      <= 1'b0;
            mismatch_q <= 1'b0;
            timer_q    <= 8'd0;
        end else begin
            state_q    <= state_d;
            go_q       <= go_d;
            n_out_q    <= n_out_d;
            result_q   <= result_d;
            valid_q    <= valid_d;
            busy_q     <= busy_d;
            err_q      <= err_d;
            mismatch_q <= mismatch_d;
            timer_q    <= timer_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start && n_ok) state_d = S_ISSUE;
            S_ISSUE: state_d = S_WAIT;
            S_WAIT:  if (done_in || timeout) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        go_d       = 1'b0;
        n_out_d    = n_out_q;
        result_d   = result_q;
        valid_d    = valid_q;
        busy_d     = busy_q;
        err_d      = err_q;
        mismatch_d = mismatch_q;
        timer_d    = timer_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (n_ok) begin
                        // go is registered here so it is high for the whole ISSUE cycle.
                        go_d       = 1'b1;
                        n_out_d    = n_in;
                        valid_d    = 1'b0;
                        err_d      = 1'b0;
                        mismatch_d = 1'b0;
                        busy_d     = 1'b1;
                    end else begin
                        err_d   = 1'b1;
                        valid_d = 1'b0;
                    end
                end
            end
            S_ISSUE: begin
                timer_d = 8'd0;
            end
            S_WAIT: begin
                if (done_in) begin
                    result_d   = result_in;
                    valid_d    = 1'b1;
                    busy_d     = 1'b0;
                    mismatch_d = capture_bad;
                end else if (timeout) begin
                    err_d   = 1'b1;
                    valid_d = 1'b0;
                    busy_d  = 1'b0;
                end else begin
                    timer_d = timer_q + 8'd1;
                end
            end
            default: ;
        endcase
    end

    assign go       = go_q;
    assign n_out    = n_out_q;
    assign result   = result_q;
    assign valid    = valid_q;
    assign busy     = busy_q;
    assign err      = err_q;
    assign mismatch = mismatch_q;

endmodule

// File: tb/tb_fact_requester.sv
// Randomized bench for fact_requester against a transaction-level model of the request rules.
module tb_fact_requester;

    localparam int T  = 12;
    localparam int NM = 12;

    logic        clk = 1'b0;
    logic        rst, start, done_in;
    logic [3:0]  n_in;
    logic [31:0] result_in;
    logic        go, valid, busy, err, mismatch;
    logic [3:0]  n_out;
    logic [31:0] result;

    fact_requester #(.TIMEOUT_CYC(T), .N_MAX(NM)) dut (
        .clk(clk), .rst(rst), .start(start), .n_in(n_in), .go(go), .n_out(n_out),
        .done_in(done_in), .result_in(result_in), .result(result), .valid(valid),
        .busy(busy), .err(err), .mismatch(mismatch)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int go_cnt   = 0;

    always @(negedge clk) if (go === 1'b1) go_cnt++;

    // Expected architectural state
    logic [31:0] m_result;
    logic        m_valid, m_err, m_mis;

    function automatic logic [31:0] fact(input int n);
        logic [31:0] p;
        p = 32'd1;
        for (int i = 2; i <= n; i++) p = p * 32'(i);
        return p;
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle(input string tag);
        check_eq({tag, "_result"}, result, m_result);
        check_eq({tag, "_valid"}, 32'(valid), 32'(m_valid));
        check_eq({tag, "_err"}, 32'(err), 32'(m_err));
        check_eq({tag, "_mis"}, 32'(mismatch), 32'(m_mis));
        check_eq({tag, "_busy"}, 32'(busy), 32'd0);
        check_eq({tag, "_go"}, 32'(go), 32'd0);
    endtask

    // d = WAIT-cycle index carrying done_in; d >= T means no reply before the timeout.
    task automatic run_req(input string tag, input int n, input int d, input logic [31:0] val, input bit noise);
        int g0;
        g0 = go_cnt;
        start = 1'b1;
        n_in  = 4'(n);
        step();
        start = 1'b0;
        if (n > NM) begin
            m_err   = 1'b1;
            m_valid = 1'b0;
            check_idle({tag, "_rej"});
            step();
            check_eq({tag, "_rej_gocnt"}, 32'(go_cnt - g0), 32'd0);
            $display("txn %s n=%0d rejected err=%0b", tag, n, err);
            return;
        end
        check_eq({tag, "_go1"}, 32'(go), 32'd1);
        check_eq({tag, "_nout"}, 32'(n_out), 32'(n));
        check_eq({tag, "_busy1"}, 32'(busy), 32'd1);
        done_in   = noise;
        start     = noise;
        result_in = $urandom;
        step();
        check_eq({tag, "_go0"}, 32'(go), 32'd0);
        for (int k = 0; k < T + 2; k++) begin
            done_in   = (k == d);
            result_in = val;
            start     = 1'($urandom);
            n_in      = 4'($urandom);
            step();
            if (k == d || k == T - 1) break;
            check_eq({tag, "_busyw"}, 32'(busy), 32'd1);
            check_eq({tag, "_noutw"}, 32'(n_out), 32'(n));
        end
        done_in = 1'b0;
        start   = 1'b0;
        if (d < T) begin
            m_result = val;
            m_valid  = 1'b1;
            m_err    = 1'b0;
`ifdef FACT_REQ_SELFCHECK_EN
            m_mis    = (val != fact(n));
`else
            m_mis    = 1'b0;
`endif
        end else begin
            m_valid = 1'b0;
            m_err   = 1'b1;
            m_mis   = 1'b0;
        end
        check_idle(tag);
        check_eq({tag, "_gocnt"}, 32'(go_cnt - g0), 32'd1);
        $display("txn %s n=%0d d=%0d result=%0h valid=%0b err=%0b mis=%0b",
                 tag, n, d, result, valid, err, mismatch);
    endtask

    initial begin
        int n, d;
        logic [31:0] v;
        rst = 1'b1; start = 1'b0; done_in = 1'b0; n_in = 4'd0; result_in = 32'd0;
        m_result = 32'd0; m_valid = 1'b0; m_err = 1'b0; m_mis = 1'b0;
        step(); step();
        rst = 1'b0;
        check_idle("reset");
        check_eq("reset_nout", 32'(n_out), 32'd0);

        run_req("basic5", 5, 9, 32'd120, 1'b0);
        run_req("range13", 13, 0, 32'd0, 1'b0);
        run_req("timeout", 3, T, 32'd6, 1'b1);
        run_req("edge_tmo", 6, T - 1, 32'd720, 1'b1);
        run_req("bad4", 4, 2, 32'd25, 1'b0);
        run_req("good4", 4, 2, 32'd24, 1'b0);

        // done_in while idle must not disturb the held result
        done_in = 1'b1; result_in = 32'hdead_beef;
        step();
        done_in = 1'b0;
        check_idle("idle_done");

        // reset mid-WAIT with coincident done_in
        start = 1'b1; n_in = 4'd7;
        step();
        start = 1'b0;
        step(); step();
        rst = 1'b1; done_in = 1'b1; result_in = 32'd5040;
        step();
        rst = 1'b0; done_in = 1'b0;
        m_result = 32'd0; m_valid = 1'b0; m_err = 1'b0; m_mis = 1'b0;
        check_idle("rst_wait");
        check_eq("rst_wait_nout", 32'(n_out), 32'd0);
        $display("txn rst_wait result=%0h valid=%0b busy=%0b", result, valid, busy);

        for (int i = 0; i < 40; i++) begin
            n = $urandom_range(0, 15);
            d = $urandom_range(0, T);
            v = ($urandom_range(0, 3) == 0) ? $urandom : fact(n);
            run_req($sformatf("rnd%0d", i), n, d, v, 1'($urandom));
            if ($urandom_range(0, 2) == 0) begin
                done_in = 1'b1; result_in = $urandom;
                step();
                done_in = 1'b0;
                check_idle($sformatf("rnd%0d_idle", i));
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fact_requester.md
FACT_REQUESTER -- requirements
Module: fact_requester

Interface
REQ-001 Parameter TIMEOUT_CYC, default 255: maximum number of WAIT cycles allowed before timeout; legal range 1..255.
REQ-002 Parameter N_MAX, default 12: largest operand accepted, since 12! fits in 32 bits.
REQ-003 clk  in  1  single clock; all state updates on the rising edge.
REQ-004 rst  in  1  reset, synchronous, active-high.
REQ-005 start  in  1  user request; sampled only in IDLE.
REQ-006 n_in  in  4  requested operand n.
REQ-007 go  out  1  one-cycle start pulse to the factorial unit.
REQ-008 n_out  out  4  operand presented to the factorial unit; held stable from ISSUE through WAIT.
REQ-009 done_in  in  1  completion strobe from the factorial unit.
REQ-010 result_in  in  32  factorial value; valid only while done_in=1.
REQ-011 result  out  32  captured factorial value.
REQ-012 valid  out  1  result holds the answer to the last accepted request.
REQ-013 busy  out  1  request in flight.
REQ-014 err  out  1  last request rejected (range) or timed out.
REQ-015 mismatch  out  1  self-check failure; see Configuration.

Function
REQ-016 FSM states: IDLE, ISSUE, WAIT; every output is driven from a register.
REQ-017 IDLE, start=1, n_in<=N_MAX:
- latch n_out<=n_in
- clear valid, err, mismatch
- set busy=1
- go to ISSUE
REQ-018 IDLE, start=1, n_in>N_MAX: set err=1, clear valid, issue no go, stay in IDLE.
REQ-019 ISSUE: go=1 for exactly one cycle, clear the timer, move to WAIT; go asserts in the cycle after start is sampled.
REQ-020 ISSUE: ignore done_in as stale.
REQ-021 WAIT, done_in=1:
- result<=result_in
- valid<=1
- busy<=0
- go to IDLE
REQ-022 WAIT, done_in=0: increment the 8-bit timer.
REQ-023 WAIT, timer reaches TIMEOUT_CYC with no done_in: err<=1, valid<=0, busy<=0, go to IDLE; result keeps its previous value.
REQ-024 done_in=1 in the same cycle the timeout would fire: done wins and no error is flagged.
REQ-025 Ignore start while busy=1.
REQ-026 Ignore done_in in IDLE; result and valid stay unchanged.
REQ-027 valid, err and result hold their values until the next accepted or rejected start.
REQ-028 Never assert go more than once per accepted request.

Reset
REQ-029 rst=1 at a clock edge forces IDLE, go=0, n_out=0, result=0, valid=0, busy=0, err=0, mismatch=0, timer=0.
REQ-030 rst takes priority over every other event, including mid-WAIT and a coincident done_in; the captured result is discarded.

Configuration
REQ-031 Macro FACT_REQ_SELFCHECK_EN, when defined:
- on capture, compare result_in against an internal table of n! for n=0..N_MAX
- set mismatch=1 on inequality
- valid still asserts
REQ-032 FACT_REQ_SELFCHECK_EN undefined: omit the table; tie mismatch to 0. The port list is identical in both builds.

Verification
REQ-033 n_in=5, start pulse, done_in with result_in=120 ten cycles after go -> one-cycle go one cycle after start, n_out=5, then result=120, valid=1, busy=0, err=0.
REQ-034 n_in=13 with N_MAX=12 -> err=1, go never asserts, busy stays 0.
REQ-035 TIMEOUT_CYC=8, no done_in -> err=1 and busy=0 after 8 WAIT cycles; valid=0.
REQ-036 done_in on the exact timeout cycle -> valid=1, err=0; second start during WAIT -> no extra go.
REQ-037 rst=1 mid-WAIT coincident with done_in -> all outputs 0 the next cycle, FSM in IDLE.
REQ-038 FACT_REQ_SELFCHECK_EN defined, n_in=4, result_in=25 -> mismatch=1, valid=1; result_in=24 -> mismatch=0.
